// File: rtl/intra_layer_block_scheduler.sv
// Steps a layer through forward-head, overlap and backward-tail phases, one
// step per rising edge of block_finish_valid_i, and reports each phase's block split.
module intra_layer_block_scheduler (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        block_finish_valid_i,
   input  logic [31:0] forward_length_i,
   input  logic [31:0] backward_length_i,
   input  logic [31:0] forward_breakpoint_i,
   input  logic [31:0] backward_breakpoint_i,
   output logic [31:0] block0_start_o,
   output logic [31:0] block0_length_o,
   output logic [31:0] block1_start_o,
   output logic [31:0] block1_length_o,
   output logic [1:0]  block_type_o
);

   typedef enum logic [1:0] {
      FWD_HEAD = 2'd0,
      OVERLAP  = 2'd1,
      BWD_TAIL = 2'd2,
      DONE     = 2'd3
   } phase_e;

   phase_e      phase_q;
   logic        finish_prev_q;
   logic        advance;
   logic [31:0] fbp;
   logic [31:0] bbp;

   // prev resets to 0, so a finish held high across reset release counts as an edge
   assign advance = block_finish_valid_i & ~finish_prev_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         phase_q       <= FWD_HEAD;
         finish_prev_q <= 1'b0;
      end else begin
         finish_prev_q <= block_finish_valid_i;
         if (advance) begin
            case (phase_q)
               FWD_HEAD: phase_q <= OVERLAP;
               OVERLAP:  phase_q <= BWD_TAIL;
               BWD_TAIL: phase_q <= DONE;
               default:  phase_q <= FWD_HEAD;
            endcase
         end
      end
   end

   assign block_type_o = phase_q;

   // clamping keeps every length subtraction below from underflowing
   assign fbp = (forward_breakpoint_i  < forward_length_i)  ? forward_breakpoint_i  : forward_length_i;
   assign bbp = (backward_breakpoint_i < backward_length_i) ? backward_breakpoint_i : backward_length_i;

   always_comb begin
      block0_start_o  = 32'd0;
      block0_length_o = 32'd0;
      block1_start_o  = 32'd0;
      block1_length_o = 32'd0;
      case (phase_q)
         FWD_HEAD: begin
            block0_length_o = fbp;
         end
         OVERLAP: begin
            block0_start_o  = fbp;
            block0_length_o = forward_length_i - fbp;
            block1_length_o = bbp;
         end
         BWD_TAIL: begin
            block0_start_o  = bbp;
            block0_length_o = backward_length_i - bbp;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_intra_layer_block_scheduler.sv
// Randomized scoreboard bench for intra_layer_block_scheduler against a
// phase-count reference model.
module tb_intra_layer_block_scheduler;

   logic        clk_i;
   logic        rst_ni;
   logic        block_finish_valid_i;
   logic [31:0] forward_length_i;
   logic [31:0] backward_length_i;
   logic [31:0] forward_breakpoint_i;
   logic [31:0] backward_breakpoint_i;
   logic [31:0] block0_start_o;
   logic [31:0] block0_length_o;
   logic [31:0] block1_start_o;
   logic [31:0] block1_length_o;
   logic [1:0]  block_type_o;

   intra_layer_block_scheduler dut (
      .clk_i                 (clk_i),
      .rst_ni                (rst_ni),
      .block_finish_valid_i  (block_finish_valid_i),
      .forward_length_i      (forward_length_i),
      .backward_length_i     (backward_length_i),
      .forward_breakpoint_i  (forward_breakpoint_i),
      .backward_breakpoint_i (backward_breakpoint_i),
      .block0_start_o        (block0_start_o),
      .block0_length_o       (block0_length_o),
      .block1_start_o        (block1_start_o),
      .block1_length_o       (block1_length_o),
      .block_type_o          (block_type_o)
   );

   typedef struct packed {
      logic [1:0]  typ;
      logic [31:0] s0;
      logic [31:0] l0;
      logic [31:0] s1;
      logic [31:0] l1;
   } out_t;

   out_t exp_q[$];
   int   checks = 0;
   int   passed = 0;

   // reference state: completed rising edges mod 4, and last sampled finish level
   int   m_phase = 0;
   bit   m_prev  = 0;

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   function automatic out_t model(input int ph, input logic [31:0] fl, bl, fb, bb);
      out_t o;
      longint unsigned f, b;
      f = (fb > fl) ? fl : fb;
      b = (bb > bl) ? bl : bb;
      o = '0;
      o.typ = ph[1:0];
      if (ph == 0) o.l0 = f[31:0];
      if (ph == 1) begin o.s0 = f[31:0]; o.l0 = 32'(fl - f); o.l1 = b[31:0]; end
      if (ph == 2) begin o.s0 = b[31:0]; o.l0 = 32'(bl - b); end
      return o;
   endfunction

   function automatic out_t actual();
      out_t a;
      a.typ = block_type_o;
      a.s0  = block0_start_o;
      a.l0  = block0_length_o;
      a.s1  = block1_start_o;
      a.l1  = block1_length_o;
      return a;
   endfunction

   task automatic compare(input string name, input out_t a, input out_t e);
      checks++;
      if (a === e) passed++;
      else $display("FAIL %s @%0t: got type=%0d b0=(%0d,%0d) b1=(%0d,%0d) want type=%0d b0=(%0d,%0d) b1=(%0d,%0d)",
                    name, $time, a.typ, a.s0, a.l0, a.s1, a.l1, e.typ, e.s0, e.l0, e.s1, e.l1);
   endtask

   always @(negedge clk_i) begin
      if (exp_q.size() > 0) compare("cycle", actual(), exp_q.pop_front());
   end

   task automatic set_inputs(input logic fin, input logic [31:0] fl, bl, fb, bb);
      block_finish_valid_i  = fin;
      forward_length_i      = fl;
      backward_length_i     = bl;
      forward_breakpoint_i  = fb;
      backward_breakpoint_i = bb;
      exp_q.push_back(model(m_phase, fl, bl, fb, bb));
      // the following clock edge sees this finish level
      if (fin && !m_prev) m_phase = (m_phase + 1) % 4;
      m_prev = fin;
   endtask

   task automatic drive(input logic fin, input logic [31:0] fl, bl, fb, bb);
      @(posedge clk_i); #1;
      set_inputs(fin, fl, bl, fb, bb);
   endtask

   // asynchronous reset mid-cycle, then release with a chosen finish level
   task automatic async_reset(input logic rel_fin);
      @(posedge clk_i); #1;
      block_finish_valid_i = 1'b0;
      #1 rst_ni = 1'b0;
      #1 compare("async_reset", actual(),
                 model(0, forward_length_i, backward_length_i, forward_breakpoint_i, backward_breakpoint_i));
      m_phase = 0;
      m_prev  = 0;
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      set_inputs(rel_fin, forward_length_i, backward_length_i, forward_breakpoint_i, backward_breakpoint_i);
   endtask

   function automatic logic [31:0] rnd_len();
      return ($urandom_range(0, 7) == 0) ? $urandom() : 32'($urandom_range(0, 20));
   endfunction

   initial begin
      logic [31:0] fl, bl, fb, bb;
      rst_ni = 1'b0;
      set_inputs(1'b0, 32'd10, 32'd4, 32'd7, 32'd3);
      @(negedge clk_i);
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      set_inputs(1'b0, 32'd10, 32'd4, 32'd7, 32'd3);

      // directed walk through all phases with pulses of 1, 2 and 3 cycles
      drive(1, 10, 4, 7, 3);
      drive(0, 10, 4, 7, 3);
      drive(1, 10, 4, 7, 3);
      drive(1, 10, 4, 7, 3);
      drive(0, 10, 4, 7, 3);
      drive(1, 10, 4, 7, 3);
      drive(1, 10, 4, 7, 3);
      drive(1, 10, 4, 7, 3);
      drive(0, 10, 4, 7, 3);
      drive(1, 10, 4, 7, 3);
      drive(0, 10, 4, 7, 3);
      // breakpoint beyond length clamps to length
      drive(0, 10, 4, 12, 3);
      drive(1, 10, 4, 12, 3);
      drive(0, 10, 4, 12, 3);
      drive(1, 10, 4, 12, 3);
      drive(0, 10, 4, 12, 3);
      async_reset(1'b1);
      drive(0, 10, 4, 12, 3);

      fl = rnd_len(); bl = rnd_len(); fb = rnd_len(); bb = rnd_len();
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 15) == 0) begin
            fl = rnd_len(); bl = rnd_len(); fb = rnd_len(); bb = rnd_len();
         end
         if ($urandom_range(0, 40) == 0) async_reset(1'($urandom_range(0, 1)));
         else drive(1'($urandom_range(0, 2) == 0), fl, bl, fb, bb);
      end

      @(negedge clk_i); #1;
      checks++;
      if (exp_q.size() == 0) passed++;
      else $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
